// File: rtl/scd_rx.sv
// -----------------------------------------------------------------------------
// scd_rx -- receiving end of the serial column-driver (SCD) link.
//
// Deserialises FRAME_W-bit frames ({addr, segments, parity}, MSB first),
// checks length / odd parity / address range on the falling edge of the
// load strobe, and writes accepted segment patterns into a per-digit
// register file. All SCD pins are asynchronous to cph1 and are synchronised
// here with two flops; edges are found by comparing the second flop with a
// third, delayed copy.
//
// Ports:
//   cph1        system clock (rising edge)
//   rst_n       asynchronous active-low reset
//   scd_sdclk   serial bit clock, data taken on its rising edge
//   scd_data    serial data, MSB first
//   scd_load_n  frame-load strobe, falling edge commits the frame
//   scd_rst_n   link reset, active low, level sensitive after sync
//   rd_addr     digit read address
//   rd_data     combinational read of digit[rd_addr] (0 when out of range)
//   err_clr     synchronous clear of err_code
//   wr_stb      one-cycle pulse on each digit write
//   wr_addr     address of the last digit write
//   err_code    sticky first error: 0 none, 1 length, 2 parity, 3 address
//   frame_cnt   count of accepted frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module scd_rx #(
    parameter int FRAME_W    = 25,
    parameter int ADDR_W     = 4,
    parameter int SEG_W      = 20,
    parameter int NUM_DIGITS = 12
) (
    input  logic              cph1,
    input  logic              rst_n,
    input  logic              scd_sdclk,
    input  logic              scd_data,
    input  logic              scd_load_n,
    input  logic              scd_rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [SEG_W-1:0]  rd_data,
    input  logic              err_clr,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        err_code,
    output logic [7:0]        frame_cnt
);

    // Bit counter must hold FRAME_W+1 so an overrun survives until the load.
    localparam int                CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_DIGITS);

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LENGTH = 2'd1;
    localparam logic [1:0] ERR_PARITY = 2'd2;
    localparam logic [1:0] ERR_ADDR   = 2'd3;

    // Synchronisers; [1] is the synced value, [2] the delayed copy for edges.
    logic [2:0] sdclk_q;
    logic [1:0] data_q;
    logic [2:0] load_q;
    logic [1:0] lrst_q;

    always_ff @(posedge cph1 or negedge rst_n) begin
        if (!rst_n) begin
            sdclk_q <= 3'b000;
            data_q  <= 2'b00;
            load_q  <= 3'b111;
            lrst_q  <= 2'b11;
        end else begin
            sdclk_q <= {sdclk_q[1:0], scd_sdclk};
            data_q  <= {data_q[0], scd_data};
            load_q  <= {load_q[1:0], scd_load_n};
            lrst_q  <= {lrst_q[0], scd_rst_n};
        end
    end

    logic sdclk_rise;
    logic load_fall;
    logic load_s;
    logic link_rst;

    assign sdclk_rise = sdclk_q[1] & ~sdclk_q[2];
    assign load_fall  = ~load_q[1] & load_q[2];
    assign load_s     = load_q[1];
    assign link_rst   = ~lrst_q[1];

    // Datapath state
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [SEG_W-1:0]   digit_q [NUM_DIGITS];
    logic [SEG_W-1:0]   digit_d [NUM_DIGITS];
    logic               wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [1:0]         err_q, err_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [1:0]         new_err;
    logic [ADDR_W-1:0]  frame_addr;

    assign frame_addr = shreg_q[FRAME_W-1 -: ADDR_W];

    always_comb begin
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        digit_d     = digit_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_cnt_d = frame_cnt_q;
        new_err     = ERR_NONE;

        if (link_rst) begin
            shreg_d  = '0;
            bitcnt_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_d[i] = '0;
            end
        end else if (load_fall) begin
            // A coincident sdclk rise is dropped: the load branch wins.
            shreg_d  = '0;
            bitcnt_d = '0;
            if (bitcnt_q != CNT_FULL) begin
                new_err = ERR_LENGTH;
            end else if ((^shreg_q) == 1'b0) begin
                new_err = ERR_PARITY;
            end else if (frame_addr >= ADDR_LIM) begin
                new_err = ERR_ADDR;
            end else begin
                digit_d[frame_addr] = shreg_q[SEG_W:1];
                wr_stb_d            = 1'b1;
                wr_addr_d           = frame_addr;
                frame_cnt_d         = frame_cnt_q + 8'd1;
            end
        end else if (sdclk_rise && load_s) begin
            shreg_d = {shreg_q[FRAME_W-2:0], data_q[1]};
            if (bitcnt_q != CNT_SAT) begin
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end
        end

        // Clear first, then a same-cycle error may load into the cleared slot.
        err_d = err_clr ? ERR_NONE : err_q;
        if (new_err != ERR_NONE && err_d == ERR_NONE) begin
            err_d = new_err;
        end
    end

    always_ff @(posedge cph1 or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= ERR_NONE;
            frame_cnt_q <= '0;
        end else begin
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            digit_q     <= digit_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr < ADDR_LIM) begin
            rd_data = digit_q[rd_addr];
        end
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign err_code  = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_scd_rx.sv
// -----------------------------------------------------------------------------
// tb_scd_rx -- self-checking bench for scd_rx.
// Frames are modelled as bit queues; commit outcome, digit contents,
// error code and frame count come from a behavioural model of the link rules.
// -----------------------------------------------------------------------------
module tb_scd_rx;

    logic        cph1;
    logic        rst_n;
    logic        scd_sdclk;
    logic        scd_data;
    logic        scd_load_n;
    logic        scd_rst_n;
    logic [3:0]  rd_addr;
    logic [19:0] rd_data;
    logic        err_clr;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;

    int checks;
    int failures;

    // Behavioural model
    bit          model_bits[$];
    logic [19:0] model_digit [12];
    logic [1:0]  model_err;
    logic [7:0]  model_cnt;
    logic [3:0]  model_last_addr;

    scd_rx dut (
        .cph1       (cph1),
        .rst_n      (rst_n),
        .scd_sdclk  (scd_sdclk),
        .scd_data   (scd_data),
        .scd_load_n (scd_load_n),
        .scd_rst_n  (scd_rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .err_clr    (err_clr),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .err_code   (err_code),
        .frame_cnt  (frame_cnt)
    );

    // Clock / reset
    initial cph1 = 1'b0;
    always #5 cph1 = ~cph1;

    function automatic void model_reset();
        model_bits.delete();
        for (int i = 0; i < 12; i++) model_digit[i] = '0;
        model_err       = 2'd0;
        model_cnt       = 8'd0;
        model_last_addr = 4'd0;
    endfunction

    // Applies the commit rules to the bits collected since the last load.
    function automatic bit model_commit();
        int          n    = model_bits.size();
        logic [24:0] f    = '0;
        int          ones = 0;
        int          a;
        logic [1:0]  e    = 2'd0;
        bit          ok   = 1'b0;
        for (int i = 0; i < n; i++) begin
            f = {f[23:0], model_bits[i]};
            ones += int'(model_bits[i]);
        end
        if (n != 25) e = 2'd1;
        else if (ones % 2 != 1) e = 2'd2;
        else begin
            a = int'(f[24:21]);
            if (a >= 12) e = 2'd3;
            else begin
                model_digit[a]  = f[20:1];
                model_last_addr = 4'(a);
                model_cnt       = model_cnt + 8'd1;
                ok              = 1'b1;
            end
        end
        if (model_err == 2'd0) model_err = e;
        model_bits.delete();
        return ok;
    endfunction

    function automatic logic [24:0] make_frame(input logic [3:0] a, input logic [19:0] seg,
                                               input bit bad);
        logic [23:0] p = {a, seg};
        return {p, ~(^p) ^ bad};
    endfunction

    // Driver tasks
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge cph1) scd_data = v[i];
            @(negedge cph1) scd_sdclk = 1'b1;
            repeat (2) @(negedge cph1);
            scd_sdclk = 1'b0;
            @(negedge cph1);
            model_bits.push_back(v[i]);
        end
    endtask

    // Drops load_n (optionally with a coincident sdclk rise) and samples wr_stb
    // after edges N+1, N+2 and N+3.
    task automatic pulse_load(input bit with_clk, output logic s1, output logic s2,
                              output logic s3);
        @(negedge cph1);
        scd_load_n = 1'b0;
        if (with_clk) scd_sdclk = 1'b1;
        @(negedge cph1);
        @(negedge cph1) s1 = wr_stb;
        @(negedge cph1) s2 = wr_stb;
        @(negedge cph1) s3 = wr_stb;
        scd_load_n = 1'b1;
        scd_sdclk  = 1'b0;
        repeat (3) @(negedge cph1);
    endtask

    task automatic pulse_err_clr();
        @(negedge cph1) err_clr = 1'b1;
        @(negedge cph1) err_clr = 1'b0;
        model_err = 2'd0;
    endtask

    // Tests
    task automatic test_reset();
        logic [19:0] exp_rd;
        checks++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL reset_wr_stb got=%0b exp=0", wr_stb); end
        checks++; if (wr_addr !== 4'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_code); end
        checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            exp_rd = (a < 12) ? model_digit[a] : 20'd0;
            checks++;
            if (rd_data !== exp_rd) begin
                failures++; $display("FAIL reset_rd[%0d] got=%h exp=%h", a, rd_data, exp_rd);
            end
        end
    endtask

    task automatic test_basic();
        logic s1, s2, s3;
        bit exp;
        send_bits({7'd0, make_frame(4'd3, 20'hA5A5A, 1'b0)}, 25);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s1 !== 1'b0) begin failures++; $display("FAIL basic_stb_n1 got=%0b exp=0", s1); end
        checks++; if (s2 !== exp) begin failures++; $display("FAIL basic_stb_n2 got=%0b exp=%0b", s2, exp); end
        checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL basic_stb_n3 got=%0b exp=0", s3); end
        checks++; if (wr_addr !== model_last_addr) begin failures++; $display("FAIL basic_wr_addr got=%0d exp=%0d", wr_addr, model_last_addr); end
        checks++; if (frame_cnt !== model_cnt) begin failures++; $display("FAIL basic_cnt got=%0d exp=%0d", frame_cnt, model_cnt); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL basic_err got=%0d exp=%0d", err_code, model_err); end
        rd_addr = 4'd3; #1;
        checks++; if (rd_data !== model_digit[3]) begin failures++; $display("FAIL basic_rd3 got=%h exp=%h", rd_data, model_digit[3]); end
    endtask

    task automatic test_length();
        logic s1, s2, s3;
        bit exp;
        send_bits($urandom, 24);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL len24_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL len24_err got=%0d exp=%0d", err_code, model_err); end
        send_bits($urandom, 27);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL len27_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL len27_err got=%0d exp=%0d", err_code, model_err); end
        send_bits({7'd0, make_frame(4'd0, 20'($urandom), 1'b0)}, 25);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL len_after_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (frame_cnt !== model_cnt) begin failures++; $display("FAIL len_after_cnt got=%0d exp=%0d", frame_cnt, model_cnt); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== model_digit[0]) begin failures++; $display("FAIL len_after_rd0 got=%h exp=%h", rd_data, model_digit[0]); end
    endtask

    task automatic test_parity_addr();
        logic s1, s2, s3;
        bit exp;
        pulse_err_clr();
        send_bits({7'd0, make_frame(4'd5, 20'($urandom), 1'b1)}, 25);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL par_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL par_err got=%0d exp=%0d", err_code, model_err); end
        rd_addr = 4'd5; #1;
        checks++; if (rd_data !== model_digit[5]) begin failures++; $display("FAIL par_rd5 got=%h exp=%h", rd_data, model_digit[5]); end
        pulse_err_clr();
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL errclr got=%0d exp=%0d", err_code, model_err); end
        send_bits({7'd0, make_frame(4'd12, 20'($urandom), 1'b0)}, 25);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL addr_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL addr_err got=%0d exp=%0d", err_code, model_err); end
        rd_addr = 4'd12; #1;
        checks++; if (rd_data !== 20'd0) begin failures++; $display("FAIL addr_rd12 got=%h exp=0", rd_data); end
    endtask

    task automatic test_link_reset();
        logic s1, s2, s3;
        bit exp;
        logic [19:0] exp_rd;
        pulse_err_clr();
        for (int a = 0; a < 12; a++) begin
            send_bits({7'd0, make_frame(4'(a), 20'($urandom) ^ 20'(a), 1'b0)}, 25);
            pulse_load(1'b0, s1, s2, s3);
            exp = model_commit();
            checks++; if (s2 !== exp) begin failures++; $display("FAIL fill_stb[%0d] got=%0b exp=%0b", a, s2, exp); end
        end
        // Link reset held low 4 cycles with one sdclk pulse inside the window.
        @(negedge cph1) scd_rst_n = 1'b0;
        @(negedge cph1); scd_data = 1'b1; scd_sdclk = 1'b1;
        @(negedge cph1) scd_sdclk = 1'b0;
        repeat (2) @(negedge cph1);
        scd_rst_n = 1'b1;
        scd_data  = 1'b0;
        repeat (3) @(negedge cph1);
        for (int i = 0; i < 12; i++) model_digit[i] = '0;
        model_bits.delete();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            exp_rd = (a < 12) ? model_digit[a] : 20'd0;
            checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL lrst_rd[%0d] got=%h exp=%h", a, rd_data, exp_rd); end
        end
        checks++; if (frame_cnt !== model_cnt) begin failures++; $display("FAIL lrst_cnt got=%0d exp=%0d", frame_cnt, model_cnt); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL lrst_err got=%0d exp=%0d", err_code, model_err); end
        send_bits({7'd0, make_frame(4'd9, 20'($urandom), 1'b0)}, 25);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL lrst_after_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL lrst_after_err got=%0d exp=%0d", err_code, model_err); end
    endtask

    task automatic test_simultaneous();
        logic s1, s2, s3;
        bit exp;
        logic [3:0] a;
        a = 4'($urandom_range(0, 11));
        send_bits({7'd0, make_frame(a, 20'($urandom), 1'b0)}, 25);
        @(negedge cph1) scd_data = 1'b1;
        pulse_load(1'b1, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL simul_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL simul_err got=%0d exp=%0d", err_code, model_err); end
        rd_addr = a; #1;
        checks++; if (rd_data !== model_digit[a]) begin failures++; $display("FAIL simul_rd got=%h exp=%h", rd_data, model_digit[a]); end
    endtask

    task automatic test_random();
        logic s1, s2, s3;
        bit exp;
        int kind;
        logic [19:0] exp_rd;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 3) == 0) pulse_err_clr();
            kind = $urandom_range(0, 9);
            if (kind == 0) send_bits($urandom, ($urandom_range(0, 1) == 0) ? 24 : 26);
            else send_bits({7'd0, make_frame(4'($urandom_range(0, 13)), 20'($urandom), kind == 1)}, 25);
            pulse_load(1'b0, s1, s2, s3);
            exp = model_commit();
            checks++; if (s1 !== 1'b0 || s2 !== exp || s3 !== 1'b0) begin
                failures++; $display("FAIL rnd_stb[%0d] got=%0b%0b%0b exp=0%0b0", it, s1, s2, s3, exp);
            end
            checks++; if (wr_addr !== model_last_addr) begin failures++; $display("FAIL rnd_wr_addr[%0d] got=%0d exp=%0d", it, wr_addr, model_last_addr); end
            checks++; if (err_code !== model_err) begin failures++; $display("FAIL rnd_err[%0d] got=%0d exp=%0d", it, err_code, model_err); end
            checks++; if (frame_cnt !== model_cnt) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", it, frame_cnt, model_cnt); end
            for (int a = 0; a < 16; a++) begin
                rd_addr = 4'(a); #1;
                exp_rd = (a < 12) ? model_digit[a] : 20'd0;
                checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL rnd_rd[%0d][%0d] got=%h exp=%h", it, a, rd_data, exp_rd); end
            end
        end
    endtask

    task automatic test_rst_mid();
        logic s1, s2, s3;
        bit exp;
        logic [19:0] exp_rd;
        send_bits($urandom, 10);
        @(negedge cph1) rst_n = 1'b0;
        repeat (2) @(negedge cph1);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge cph1);
        checks++; if (frame_cnt !== model_cnt) begin failures++; $display("FAIL rstmid_cnt0 got=%0d exp=%0d", frame_cnt, model_cnt); end
        send_bits({7'd0, make_frame(4'd7, 20'($urandom), 1'b0)}, 25);
        pulse_load(1'b0, s1, s2, s3);
        exp = model_commit();
        checks++; if (s2 !== exp) begin failures++; $display("FAIL rstmid_stb got=%0b exp=%0b", s2, exp); end
        checks++; if (err_code !== model_err) begin failures++; $display("FAIL rstmid_err got=%0d exp=%0d", err_code, model_err); end
        checks++; if (frame_cnt !== model_cnt) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=%0d", frame_cnt, model_cnt); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            exp_rd = (a < 12) ? model_digit[a] : 20'd0;
            checks++; if (rd_data !== exp_rd) begin failures++; $display("FAIL rstmid_rd[%0d] got=%h exp=%h", a, rd_data, exp_rd); end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        scd_sdclk  = 1'b0;
        scd_data   = 1'b0;
        scd_load_n = 1'b1;
        scd_rst_n  = 1'b1;
        rd_addr    = 4'd0;
        err_clr    = 1'b0;
        model_reset();
        repeat (3) @(negedge cph1);
        rst_n = 1'b1;
        repeat (3) @(negedge cph1);

        test_reset();
        test_basic();
        test_length();
        test_parity_addr();
        test_link_reset();
        test_simultaneous();
        test_random();
        test_rst_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
